ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (for example 0xED to set the keyboard LEDs, or 0xFF for reset) from the FPGA to the keyboard over the shared open-drain ps2_clk/ps2_data lines. It performs the inhibit/request-to-send sequence, shifts out 8 data bits, odd parity and stop on device-generated clock edges, then checks the device's line-level acknowledge bit. It sits beside the PS/2 receive path in the keyboard subsystem. `busy` is provided so the receive path can discard bits clocked while the host transmits.

## Interface
- INHIBIT_CYCLES, 5000, number of clk cycles ps2_clk is held low before request-to-send (100 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000, clk cycles allowed from clock release to the ack edge (15 ms at 50 MHz).
- clk  input  1  system clock; all logic on posedge.
- clrn  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw PS/2 clock line level, asynchronous.
- ps2_data  input  1  raw PS/2 data line level, asynchronous.
- ps2_clk_oe  output  1  1 = pull ps2_clk low; 0 = release the line.
- ps2_data_oe  output  1  1 = pull ps2_data low; 0 = release the line.
- tx_data  input  8  command byte.
- tx_valid  input  1  request to send tx_data.
- tx_ready  output  1  high only in IDLE. A byte is accepted on tx_valid & tx_ready.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a transfer ends.
- ack_err  output  1  valid with done; 1 = device did not acknowledge.
- timeout  output  1  valid with done; 1 = TIMEOUT_CYCLES expired.

## Operation
- ps2_clk and ps2_data each pass through a 2-flop synchronizer. A falling edge (fe) is synchronized-previous 1 and synchronized-current 0.
- On accept, tx_data and its odd parity bit (~^tx_data) are latched into an 11-bit frame.
- States and behaviour:
  - IDLE: both oe 0; tx_ready 1. On accept go to INHIBIT.
  - INHIBIT: clk_oe 1 for exactly INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: clk_oe 1 and data_oe 1 for exactly one cycle (start bit 0), then go to SHIFT.
  - SHIFT: clk_oe 0. The bit counter goes 0..9. On each fe, data_oe is set to ~bit: fe 1..8 drive d0..d7, fe 9 drives parity, fe 10 drives the stop bit as data_oe 0. Go to ACK after fe 10.
  - ACK: on the next fe, sample synchronized ps2_data; 0 = acknowledged, 1 sets ack_err. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until synchronized ps2_clk and ps2_data are both 1, then pulse done and go to IDLE.
- Timeout:
  - The timeout counter starts at REQ exit and is checked in SHIFT and ACK.
  - On expiry: both oe go to 0, timeout 1 and done 1 in the same cycle, then IDLE.
  - On timeout, ack_err is 0.
- An fe seen in IDLE, INHIBIT or REQ is ignored. tx_valid while busy is ignored; the byte is not queued.
- ack_err and timeout hold their values until the next accept. They clear on accept.

## Timing
- Reset values: ps2_clk_oe 0, ps2_data_oe 0, tx_ready 1, busy 0, done 0, ack_err 0, timeout 0, state IDLE.
- clrn asserted mid-transfer releases both lines immediately (asynchronous). No done pulse is produced.
- Accept cycle N: clk_oe rises at N+1 and stays high through N+INHIBIT_CYCLES. REQ is cycle N+INHIBIT_CYCLES+1. clk_oe falls at N+INHIBIT_CYCLES+2.
- data_oe updates 3 cycles after the physical falling edge (2 sync stages plus 1 register). This is well inside the ≥30 µs low half-period.
- done asserts the cycle after both lines are seen high in WAIT_IDLE. tx_ready rises in the cycle after done.
- Counters are $clog2(param+1) bits wide and saturate. They never wrap.

## Configuration
- PS2_TX_RETRY_EN defined:
  - On ack_err or timeout, the block re-enters INHIBIT once with the same latched frame. No done pulse is produced for the failed first attempt.
  - done, with the status flags, fires only after the second attempt.
- PS2_TX_RETRY_EN undefined: done fires after the first attempt, as described above.

## Structure
- Shared package ps2_pkg holds:
  - typedef enum logic [2:0] ps2_tx_state_t {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE}.
  - Command constants PS2_CMD_SET_LEDS = 8'hED, PS2_CMD_ECHO = 8'hEE, PS2_CMD_RESET = 8'hFF.
  - Response constants PS2_RSP_ACK = 8'hFA, PS2_RSP_RESEND = 8'hFE.
- Sub-module ps2_sync_edge provides the 2-flop synchronizer plus falling-edge detector. It is instantiated for ps2_clk and ps2_data and is reusable by the receive path.

## Test plan
Bench uses INHIBIT_CYCLES=10, TIMEOUT_CYCLES=2000 and a device model clocking at 40 clk cycles per bit.
- Send 0xED with the device acking:
  - clk_oe high exactly 10 cycles, then one REQ cycle with data_oe=1.
  - Device samples bits 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1.
  - done pulses once with ack_err=0 and timeout=0.
- Send 0x00: device samples parity=1. Send 0x01: device samples parity=0.
- Device holds ps2_data high at the ack edge -> done with ack_err=1. With PS2_TX_RETRY_EN, exactly two inhibit sequences occur, then a single done.
- Device never clocks after clock release -> after 2000 cycles both oe are 0 and done=1, timeout=1.
- tx_valid held high during busy with tx_data changing -> only the first byte is transmitted and tx_ready stays 0 until after done.
- clrn pulsed low at data bit 4 -> both oe drop in the same cycle, no done pulse, and the next tx_valid starts a clean INHIBIT.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 types and command/response codes used by the keyboard subsystem.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 line plus a falling-edge detector.
module ps2_sync_edge (
  input  logic clk,
  input  logic clrn,
  input  logic async_in,
  output logic sync_out,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Lines idle high, so all stages reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_out = sync_q;
  assign fall     = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter (inhibit, request-to-send, shift, ack).
// Define PS2_TX_RETRY_EN to retry a failed (nack/timeout) transfer once.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_t state;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic [3:0]    bit_cnt;
  logic [10:0]   frame;

  logic clk_s;
  logic clk_fe;
  logic data_s;
  logic data_fe_unused;
  logic to_expired;
  logic nack_seen;
  logic retry_ok;

  ps2_sync_edge u_clk_sync (
    .clk      (clk),
    .clrn     (clrn),
    .async_in (ps2_clk),
    .sync_out (clk_s),
    .fall     (clk_fe)
  );

  ps2_sync_edge u_data_sync (
    .clk      (clk),
    .clrn     (clrn),
    .async_in (ps2_data),
    .sync_out (data_s),
    .fall     (data_fe_unused)
  );

  assign to_expired = ((state == SHIFT) || (state == ACK)) && (to_cnt == TO_LAST);
  assign nack_seen  = (state == ACK) && clk_fe && data_s;

`ifdef PS2_TX_RETRY_EN
  logic retried;
  assign retry_ok = ~retried;
`else
  assign retry_ok = 1'b0;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout     <= 1'b0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      bit_cnt     <= '0;
      frame       <= '0;
`ifdef PS2_TX_RETRY_EN
      retried     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      // A failed first attempt replays the latched frame from the inhibit phase.
      if (retry_ok && (to_expired || nack_seen)) begin
        state       <= INHIBIT;
        ps2_clk_oe  <= 1'b1;
        ps2_data_oe <= 1'b0;
        inh_cnt     <= '0;
`ifdef PS2_TX_RETRY_EN
        retried     <= 1'b1;
`endif
      end else begin
        case (state)
          IDLE: begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            if (tx_valid && tx_ready) begin
              frame      <= {1'b1, odd_parity(tx_data), tx_data, 1'b0};
              ack_err    <= 1'b0;
              timeout    <= 1'b0;
              inh_cnt    <= '0;
              ps2_clk_oe <= 1'b1;
              tx_ready   <= 1'b0;
              busy       <= 1'b1;
              state      <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
              retried    <= 1'b0;
`endif
            end
          end
          INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
              ps2_data_oe <= 1'b1;
              state       <= REQ;
            end else begin
              inh_cnt <= inh_cnt + IW'(1);
            end
          end
          REQ: begin
            ps2_clk_oe <= 1'b0;
            to_cnt     <= '0;
            bit_cnt    <= '0;
            state      <= SHIFT;
          end
          SHIFT, ACK: begin
            if (to_expired) begin
              ps2_clk_oe  <= 1'b0;
              ps2_data_oe <= 1'b0;
              timeout     <= 1'b1;
              done        <= 1'b1;
              state       <= IDLE;
            end else begin
              to_cnt <= to_cnt + TW'(1);
              if (clk_fe) begin
                if (state == SHIFT) begin
                  // Bit k of the frame goes out on falling edge k; the start bit is already on the line.
                  ps2_data_oe <= ~frame[bit_cnt + 4'd1];
                  if (bit_cnt == 4'd9) state <= ACK;
                  else bit_cnt <= bit_cnt + 4'd1;
                end else begin
                  ack_err <= data_s;
                  state   <= WAIT_IDLE;
                end
              end
            end
          end
          WAIT_IDLE: begin
            if (clk_s && data_s) begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 keyboard on the open-drain lines.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 10;
  localparam int TO   = 2000;
  localparam int HALF = 20;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 2;
`else
  localparam int ATTEMPTS = 1;
`endif

  typedef struct {
    logic [7:0] data;
    logic       nack;
    logic       exp_parity;
    logic       exp_ack_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       clrn;
  logic       ps2_clk_line;
  logic       ps2_data_line;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout;
  logic       dev_clk_low;
  logic       dev_data_low;

  int n_compared   = 0;
  int n_mismatched = 0;
  int done_count   = 0;
  int inhibit_starts = 0;
  logic       clk_oe_prev = 1'b0;
  logic       done_ack_err = 1'b0;
  logic       done_timeout = 1'b0;
  logic [1:0] done_oe = 2'b00;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .clrn        (clrn),
    .ps2_clk     (ps2_clk_line),
    .ps2_data    (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .ack_err     (ack_err),
    .timeout     (timeout)
  );

  // Event monitor: counts inhibit sequences and done pulses, captures status at done.
  always @(posedge clk) begin
    #1;
    if (ps2_clk_oe && !clk_oe_prev) inhibit_starts++;
    clk_oe_prev = ps2_clk_oe;
    if (done) begin
      done_count++;
      done_ack_err = ack_err;
      done_timeout = timeout;
      done_oe      = {ps2_clk_oe, ps2_data_oe};
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "[TB] watchdog");
  end

  // Reference parity: count the ones and make the total odd.
  function automatic logic modelParity(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Accept a byte, then check the inhibit and request-to-send timing.
  task automatic applyStimulus(input logic [7:0] d);
    int inh = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    checkOutput("tx_ready_before_accept", tx_ready, 1);
    @(negedge clk);
    tx_valid = 1'b0;
    checkOutput("ack_err_cleared_on_accept", ack_err, 0);
    checkOutput("timeout_cleared_on_accept", timeout, 0);
    checkOutput("busy_after_accept", busy, 1);
    while (ps2_clk_oe && !ps2_data_oe && inh < 100) begin
      inh++;
      @(negedge clk);
    end
    checkOutput("inhibit_cycles", inh, INH);
    checkOutput("req_both_oe", {ps2_clk_oe, ps2_data_oe}, 2'b11);
    @(negedge clk);
    checkOutput("clk_released_after_req", ps2_clk_oe, 0);
    checkOutput("start_bit_driven", ps2_data_oe, 1);
  endtask

  // Keyboard side of a host-to-device frame; abort_at >= 0 pulses clrn during that bit.
  task automatic deviceReceive(input logic nack, input int abort_at,
                               output logic [9:0] bits, output logic ok);
    int n = 0;
    ok   = 1'b0;
    bits = '0;
    while (!(ps2_data_line == 1'b0 && ps2_clk_line == 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) return;
    repeat (10) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      dev_clk_low = 1'b1;
      if (k == abort_at) begin
        repeat (10) @(negedge clk);
        checkOutput("data_oe_before_reset", ps2_data_oe, 1);
        #2 clrn = 1'b0;
        #1;
        checkOutput("oe_dropped_on_reset", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        ok = 1'b1;
        return;
      end
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      bits[k] = ps2_data_line;
      repeat (HALF) @(negedge clk);
    end
    if (!nack) dev_data_low = 1'b1;
    repeat (5) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    dev_data_low = 1'b0;
    ok = 1'b1;
  endtask

  task automatic waitDone(input int d0, input int limit, output int waited);
    waited = 0;
    while (done_count == d0 && waited < limit) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic runTransfer(input logic [7:0] d, input logic nack,
                             input logic exp_parity, input logic exp_ack_err);
    int d0 = done_count;
    int i0 = inhibit_starts;
    int w;
    int attempts = nack ? ATTEMPTS : 1;
    logic [9:0] bits;
    logic ok;
    applyStimulus(d);
    for (int a = 0; a < attempts; a++) begin
      deviceReceive(nack, -1, bits, ok);
      checkOutput("device_saw_request", ok, 1);
      checkOutput("data_bits", bits[7:0], d);
      checkOutput("parity_bit", bits[8], exp_parity);
      checkOutput("stop_bit", bits[9], 1);
    end
    waitDone(d0, 300, w);
    repeat (5) @(negedge clk);
    checkOutput("done_pulses", done_count - d0, 1);
    checkOutput("ack_err_at_done", done_ack_err, exp_ack_err);
    checkOutput("timeout_at_done", done_timeout, 0);
    checkOutput("inhibit_sequences", inhibit_starts - i0, attempts);
    checkOutput("tx_ready_after_done", tx_ready, 1);
  endtask

  initial begin
    vec_t vecs[6];
    int d0;
    int i0;
    int c;
    int lo;
    int hi;
    int ready_hi;
    logic [9:0] bits;
    logic ok;
    logic [7:0] rb;
    logic rn;

    vecs[0] = '{PS2_CMD_SET_LEDS, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h00,            1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h01,            1'b0, 1'b0, 1'b0};
    vecs[3] = '{PS2_CMD_RESET,    1'b0, 1'b1, 1'b0};
    vecs[4] = '{PS2_CMD_ECHO,     1'b1, 1'b1, 1'b1};
    vecs[5] = '{8'h80,            1'b0, 1'b0, 1'b0};

    clrn = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_clk_oe", ps2_clk_oe, 0);
    checkOutput("reset_data_oe", ps2_data_oe, 0);
    checkOutput("reset_tx_ready", tx_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_ack_err", ack_err, 0);
    checkOutput("reset_timeout", timeout, 0);
    clrn = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] table vectors");
    for (int i = 0; i < 6; i++)
      runTransfer(vecs[i].data, vecs[i].nack, vecs[i].exp_parity, vecs[i].exp_ack_err);

    $display("[TB] randomized bytes");
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom_range(0, 255));
      rn = ($urandom_range(0, 3) == 0);
      runTransfer(rb, rn, modelParity(rb), rn);
    end

    $display("[TB] device silent -> timeout");
    d0 = done_count;
    applyStimulus(PS2_CMD_RESET);
    c = 0;
    while (done_count == d0 && c < 9000) begin
      @(negedge clk);
      c++;
    end
`ifdef PS2_TX_RETRY_EN
    lo = 2 * TO + INH - 1; hi = 2 * TO + INH + 3;
`else
    lo = TO - 2; hi = TO + 2;
`endif
    n_compared++;
    if (!(c >= lo && c <= hi)) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_latency: got %0d expected %0d..%0d", c, lo, hi);
    end
    checkOutput("timeout_flag", done_timeout, 1);
    checkOutput("timeout_ack_err", done_ack_err, 0);
    checkOutput("timeout_oe_released", done_oe, 2'b00);
    repeat (3) @(negedge clk);
    checkOutput("timeout_single_done", done_count - d0, 1);

    $display("[TB] tx_valid held while busy");
    d0 = done_count;
    i0 = inhibit_starts;
    ready_hi = 0;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    fork
      deviceReceive(1'b0, -1, bits, ok);
      begin
        for (int n = 0; n < 3000 && done_count == d0; n++) begin
          if (tx_ready) ready_hi++;
          tx_data = 8'($urandom_range(0, 255));
          @(negedge clk);
        end
        tx_valid = 1'b0;
      end
    join
    checkOutput("held_valid_tx_ready_low", ready_hi, 0);
    checkOutput("held_valid_ready_at_done", tx_ready, 0);
    checkOutput("held_valid_first_byte", bits[7:0], 8'hA5);
    @(negedge clk);
    checkOutput("held_valid_ready_after_done", tx_ready, 1);
    repeat (20) @(negedge clk);
    checkOutput("held_valid_one_done", done_count - d0, 1);
    checkOutput("held_valid_one_inhibit", inhibit_starts - i0, 1);

    $display("[TB] reset during data bit 4");
    d0 = done_count;
    applyStimulus(PS2_CMD_SET_LEDS);
    deviceReceive(1'b0, 4, bits, ok);
    checkOutput("abort_device_reached", ok, 1);
    repeat (100) @(negedge clk);
    checkOutput("abort_no_done", done_count - d0, 0);
    checkOutput("abort_tx_ready", tx_ready, 1);
    runTransfer(PS2_CMD_SET_LEDS, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
